// File: rtl/udp_tx_arb.sv
//==============================================================================
// Module  : udp_tx_arb
// Purpose : Packet-atomic round-robin arbiter feeding the UDP header-prepend
//           payload input. Optional packet counters via UDP_TX_ARB_STATS_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module udp_tx_arb #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int N_SRC           = 4,
  parameter int SEL_W           = $clog2(N_SRC),
  parameter int CNT_W           = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_SRC*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_SRC*AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [N_SRC-1:0]                   s_axis_tvalid,
  output logic [N_SRC-1:0]                   s_axis_tready,
  input  logic [N_SRC-1:0]                   s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [SEL_W-1:0]                   m_axis_tid,
  output logic                               busy
`ifdef UDP_TX_ARB_STATS_EN
  ,
  input  logic                               stat_clr,
  output logic [N_SRC*CNT_W-1:0]             stat_pkt_cnt
`endif
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             req_any;
  logic [SEL_W-1:0] pick;
  logic [SEL_W:0]   cand;
  logic             pkt_done;
  int               sel_idx;

  assign sel_idx = int'(grant_q);

  // Descending scan so the last hit (smallest offset from rr_ptr) wins.
  always_comb begin
    req_any = 1'b0;
    pick    = rr_ptr_q;
    cand    = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N_SRC)) cand = cand - (SEL_W+1)'(N_SRC);
      if (s_axis_tvalid[cand[SEL_W-1:0]]) begin
        req_any = 1'b1;
        pick    = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      m_axis_tdata           = s_axis_tdata[sel_idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      m_axis_tkeep           = s_axis_tkeep[sel_idx*KEEP_W +: KEEP_W];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      m_axis_tid             = grant_q;
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign busy     = (state_q == BUSY);
  assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // The pointer moves only when a packet completes, never on grant.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == SEL_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef UDP_TX_ARB_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q [N_SRC];
  logic [CNT_W-1:0] pkt_cnt_d [N_SRC];

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
    end
    if (stat_clr) begin
      for (int i = 0; i < N_SRC; i++) begin
        pkt_cnt_d[i] = '0;
      end
    end else if (pkt_done) begin
      pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_stat_pack
    assign stat_pkt_cnt[gi*CNT_W +: CNT_W] = pkt_cnt_q[gi];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_arb.sv
//==============================================================================
// Module  : tb_udp_tx_arb
// Purpose : Randomized scoreboard bench for udp_tx_arb (default build).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_udp_tx_arb;

  localparam int N = 4;
  localparam int W = 32;
  localparam int K = W / 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
    logic [1:0]   tid;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_tdata;
  logic [N*K-1:0] s_tkeep;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tready;
  logic [N-1:0]   s_tlast;
  logic [W-1:0]   m_tdata;
  logic [K-1:0]   m_tkeep;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;
  logic [1:0]     m_tid;
  logic           busy;

  udp_tx_arb #(.AXIS_DATA_WIDTH(W), .N_SRC(N)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  beat_t src_q [N][$];   // what each source still has to send
  beat_t mq    [N][$];   // reference model's view of pending packets
  exp_t  sb [$];
  int    mptr = 0;
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  mon_en  = 1'b0;
  logic  gap_en  = 1'b0;
  logic  rdy_rand = 1'b0;
  logic [N-1:0] hs, first, shown;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_beat(input int s, input logic [W-1:0] d, input logic [K-1:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    src_q[s].push_back(b);
    mq[s].push_back(b);
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) add_beat(s, $urandom, K'($urandom), (b == len - 1));
  endtask

  // Packet-level round robin: first pending source at or after mptr, modulo N.
  task automatic predict();
    int    s;
    beat_t b;
    exp_t  e;
    forever begin
      s = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr + k) % N;
        if (s < 0 && mq[c].size() > 0) s = c;
      end
      if (s < 0) break;
      do begin
        b = mq[s].pop_front();
        e.data = b.data; e.keep = b.keep; e.last = b.last; e.tid = 2'(s);
        sb.push_back(e);
      end while (!b.last);
      mptr = (s + 1) % N;
    end
  endtask

  task automatic wait_drain(input string name);
    int  cyc;
    logic done;
    done = 1'b0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk); #3;
      done = (sb.size() == 0);
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // Source and sink driver: inputs change only on the falling edge.
  initial begin
    beat_t b;
    logic  v;
    hs = '0; first = '1; shown = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          first[i] = b.last;
          shown[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          v = shown[i] | first[i] | ~gap_en | ($urandom_range(3) != 0);
          s_tvalid[i] = v;
          s_tdata[i*W +: W] = b.data;
          s_tkeep[i*K +: K] = b.keep;
          s_tlast[i] = b.last;
          shown[i] = v;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tdata[i*W +: W] = '0;
          s_tkeep[i*K +: K] = '0;
          s_tlast[i] = 1'b0;
        end
      end
      m_tready = rdy_rand ? ($urandom_range(9) < 7) : 1'b1;
      #1;
      hs = s_tvalid & s_tready;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic   prev_done;
    exp_t   e;
    logic [N-1:0] exp_rdy;
    prev_done = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!mon_en || rst) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          n_tests++;
          if (busy || m_tvalid) begin
            n_fail++;
            $display("FAIL bubble: busy=%b tvalid=%b, expected both 0", busy, m_tvalid);
          end
        end
        prev_done = 1'b0;
        if (busy) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL grant: busy=1 with nothing expected");
          end else begin
            exp_rdy = m_tready ? (N'(1) << sb[0].tid) : '0;
            if (s_tready !== exp_rdy || m_tid !== sb[0].tid) begin
              n_fail++;
              $display("FAIL grant: tready=%b tid=%0d, expected tready=%b tid=%0d",
                       s_tready, m_tid, exp_rdy, sb[0].tid);
            end
          end
        end
        if (m_tvalid && m_tready) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL beat: unexpected beat data=%h", m_tdata);
          end else begin
            e = sb.pop_front();
            if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last || m_tid !== e.tid) begin
              n_fail++;
              $display("FAIL beat: got data=%h keep=%h last=%b tid=%0d, expected data=%h keep=%h last=%b tid=%0d",
                       m_tdata, m_tkeep, m_tlast, m_tid, e.data, e.keep, e.last, e.tid);
            end
          end
          prev_done = m_tlast;
        end
      end
    end
  end

  initial begin
    logic hit;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_tdata),  64'd0);
    chk("rst_m_tkeep",  64'(m_tkeep),  64'd0);
    chk("rst_m_tid",    64'(m_tid),    64'd0);
    chk("rst_busy",     64'(busy),     64'd0);

    // Reset during beat 2 of a 4-beat packet from source 1.
    add_beat(1, 32'h11111111, 4'hF, 1'b0);
    add_beat(1, 32'h22222222, 4'hF, 1'b0);
    add_beat(1, 32'h33333333, 4'hF, 1'b0);
    add_beat(1, 32'h44444444, 4'hF, 1'b1);
    add_beat(2, 32'hAAAA0002, 4'hF, 1'b1);
    add_beat(3, 32'hBBBB0003, 4'h3, 1'b1);
    rst = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk); #3;
      hit = (src_q[1].size() == 3);
    end
    chk("midpkt_reached", 64'(hit), 64'd1);
    chk("midpkt_tid", 64'(m_tid), 64'd1);
    rst = 1'b1;
    src_q[1].delete(); mq[1].delete();
    hs = '0; first[1] = 1'b1; shown[1] = 1'b0;
    @(negedge clk); #3;
    chk("midrst_busy",     64'(busy),     64'd0);
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_m_tdata",  64'(m_tdata),  64'd0);
    chk("midrst_m_tid",    64'(m_tid),    64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    mptr = 0;
    predict();
    mon_en = 1'b1;
    rst = 1'b0;
    wait_drain("drain_after_reset");

    // Every source holds two 2-beat packets: strict rotation expected.
    for (int s = 0; s < N; s++) begin add_pkt(s, 2); add_pkt(s, 2); end
    predict();
    wait_drain("drain_fairness");

    // Single beat from source 3, then source 0 and 1 after the wrap.
    add_beat(3, 32'hC0FFEE03, 4'b0011, 1'b1);
    predict();
    wait_drain("drain_single");
    add_pkt(1, 2); add_pkt(0, 3);
    predict();
    wait_drain("drain_wrap");

    // Randomized rounds with source gaps and sink back-pressure.
    gap_en = 1'b1; rdy_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < N; s++) begin
        int np;
        np = $urandom_range(3);
        for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 4));
      end
      predict();
      wait_drain("drain_random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
